// File: rtl/ram_pkg.sv
// Shared constants and helpers for the parametrised true-dual-port RAM family.
package ram_pkg;

  localparam int WM_WRITE_FIRST = 0;
  localparam int WM_READ_FIRST  = 1;
  localparam int WM_NO_CHANGE   = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int nbytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/ram_tdp_port_out.sv
// Per-port output path: read latch with write-mode selection and SRVAL reset,
// followed by an optional pipeline register.
module ram_tdp_port_out
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    WRITE_MODE = 0,
  parameter int                    DO_REG     = 0,
  parameter logic [DATA_WIDTH-1:0] SRVAL      = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we_any,
  input  logic                  addr_ok,
  input  logic                  port_rst,
  input  logic                  regce,
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] new_word,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] latch_q;
  logic [DATA_WIDTH-1:0] pipe_q;

  // Port reset wins over the data path; out-of-range accesses read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      latch_q <= SRVAL;
    end else if (en) begin
      if (port_rst)
        latch_q <= SRVAL;
      else if (!addr_ok)
        latch_q <= '0;
      else if (!we_any)
        latch_q <= old_word;
      else if (WRITE_MODE == WM_WRITE_FIRST)
        latch_q <= new_word;
      else if (WRITE_MODE == WM_READ_FIRST)
        latch_q <= old_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || port_rst)
      pipe_q <= SRVAL;
    else if (regce)
      pipe_q <= latch_q;
  end

  assign dout = (DO_REG != 0) ? pipe_q : latch_q;

endmodule

// File: rtl/ram_tdp_param.sv
// Single-clock true-dual-port RAM with byte enables, per-port write modes,
// optional output register, collision and address-range flags.
module ram_tdp_param
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    BYTE_WIDTH   = 8,
  parameter int                    DEPTH        = 512,
  parameter int                    ADDR_WIDTH   = 9,
  parameter int                    WRITE_MODE_A = 0,
  parameter int                    WRITE_MODE_B = 0,
  parameter int                    DO_REG       = 0,
  parameter logic [DATA_WIDTH-1:0] SRVAL_A      = '0,
  parameter logic [DATA_WIDTH-1:0] SRVAL_B      = '0,
  parameter logic [DATA_WIDTH-1:0] INIT_WORD    = '0
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             ENA,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] WEA,
  input  logic [ADDR_WIDTH-1:0]            ADDRA,
  input  logic [DATA_WIDTH-1:0]            DIA,
  input  logic                             RSTA,
  input  logic                             REGCEA,
  output logic [DATA_WIDTH-1:0]            DOA,
  input  logic                             ENB,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] WEB,
  input  logic [ADDR_WIDTH-1:0]            ADDRB,
  input  logic [DATA_WIDTH-1:0]            DIB,
  input  logic                             RSTB,
  input  logic                             REGCEB,
  output logic [DATA_WIDTH-1:0]            DOB,
  output logic                             COLL,
  output logic                             ADDR_ERR
);

  localparam int                    NB      = nbytes(DATA_WIDTH, BYTE_WIDTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_WORD};

  logic                  a_ok, b_ok;
  logic [DATA_WIDTH-1:0] old_a, old_b, new_a, new_b;
  logic                  coll_q, aerr_q;

  assign a_ok = ({1'b0, ADDRA} < DEPTH_L);
  assign b_ok = ({1'b0, ADDRB} < DEPTH_L);

  // Old word is the pre-write contents; new word merges this port's own lanes.
  always_comb begin
    old_a = a_ok ? mem[ADDRA] : '0;
    old_b = b_ok ? mem[ADDRB] : '0;
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (WEA[i]) new_a[i*BYTE_WIDTH +: BYTE_WIDTH] = DIA[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (WEB[i]) new_b[i*BYTE_WIDTH +: BYTE_WIDTH] = DIB[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Port A lanes are scheduled after port B so A wins on overlapping bytes.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < NB; i++) begin
        if (ENB && b_ok && WEB[i])
          mem[ADDRB][i*BYTE_WIDTH +: BYTE_WIDTH] <= DIB[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (ENA && a_ok && WEA[i])
          mem[ADDRA][i*BYTE_WIDTH +: BYTE_WIDTH] <= DIA[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      coll_q <= 1'b0;
      aerr_q <= 1'b0;
    end else begin
      coll_q <= ENA && ENB && a_ok && b_ok && (ADDRA == ADDRB) && (|(WEA & WEB));
      aerr_q <= (ENA && !a_ok) || (ENB && !b_ok);
    end
  end

  assign COLL     = coll_q;
  assign ADDR_ERR = aerr_q;

  ram_tdp_port_out #(
    .DATA_WIDTH (DATA_WIDTH),
    .WRITE_MODE (WRITE_MODE_A),
    .DO_REG     (DO_REG),
    .SRVAL      (SRVAL_A)
  ) u_out_a (
    .clk      (CLK),
    .rst      (RST),
    .en       (ENA),
    .we_any   (|WEA),
    .addr_ok  (a_ok),
    .port_rst (RSTA),
    .regce    (REGCEA),
    .old_word (old_a),
    .new_word (new_a),
    .dout     (DOA)
  );

  ram_tdp_port_out #(
    .DATA_WIDTH (DATA_WIDTH),
    .WRITE_MODE (WRITE_MODE_B),
    .DO_REG     (DO_REG),
    .SRVAL      (SRVAL_B)
  ) u_out_b (
    .clk      (CLK),
    .rst      (RST),
    .en       (ENB),
    .we_any   (|WEB),
    .addr_ok  (b_ok),
    .port_rst (RSTB),
    .regce    (REGCEB),
    .old_word (old_b),
    .new_word (new_b),
    .dout     (DOB)
  );

endmodule

// File: tb/tb_ram_tdp_param.sv
// Directed bench: three RAM instances (write-first, read-first/no-change,
// registered output) share one stimulus stream and thus identical contents.
module tb_ram_tdp_param;

  logic        clk = 1'b0;
  logic        rst, ena, enb, rsta, rstb, regcea, regceb;
  logic [3:0]  wea, web;
  logic [8:0]  addra, addrb;
  logic [31:0] dia, dib;

  logic [31:0] doa_wf, dob_wf, doa_rf, dob_nc, doa_pr, dob_pr;
  logic        coll_wf, aerr_wf, coll_rf, aerr_rf, coll_pr, aerr_pr;

  int checks_run    = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  ram_tdp_param #(
    .DEPTH(500), .WRITE_MODE_A(0), .WRITE_MODE_B(0), .DO_REG(0),
    .SRVAL_A(32'h000000FF), .SRVAL_B(32'hA5A5A5A5)
  ) u_wf (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .RSTA(rsta), .REGCEA(regcea), .DOA(doa_wf),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .RSTB(rstb), .REGCEB(regceb), .DOB(dob_wf),
    .COLL(coll_wf), .ADDR_ERR(aerr_wf)
  );

  ram_tdp_param #(
    .DEPTH(500), .WRITE_MODE_A(1), .WRITE_MODE_B(2), .DO_REG(0),
    .SRVAL_A(32'h000000FF), .SRVAL_B(32'hA5A5A5A5)
  ) u_rf (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .RSTA(rsta), .REGCEA(regcea), .DOA(doa_rf),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .RSTB(rstb), .REGCEB(regceb), .DOB(dob_nc),
    .COLL(coll_rf), .ADDR_ERR(aerr_rf)
  );

  ram_tdp_param #(
    .DEPTH(500), .WRITE_MODE_A(0), .WRITE_MODE_B(0), .DO_REG(1),
    .SRVAL_A(32'h000000FF), .SRVAL_B(32'hA5A5A5A5)
  ) u_pr (
    .CLK(clk), .RST(rst),
    .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .RSTA(rsta), .REGCEA(regcea), .DOA(doa_pr),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .RSTB(rstb), .REGCEB(regceb), .DOB(dob_pr),
    .COLL(coll_pr), .ADDR_ERR(aerr_pr)
  );

  // Drives both ports for one clock edge; outputs are stable 1ns after it.
  task automatic applyStimulus(
    input logic a_en, input logic [3:0] a_we, input logic [8:0] a_addr, input logic [31:0] a_di,
    input logic b_en, input logic [3:0] b_we, input logic [8:0] b_addr, input logic [31:0] b_di);
    ena = a_en; wea = a_we; addra = a_addr; dia = a_di;
    enb = b_en; web = b_we; addrb = b_addr; dib = b_di;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'h0, 9'd0, 32'h0, 1'b0, 4'h0, 9'd0, 32'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_run++;
    if (got === exp)
      checks_passed++;
    else
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  initial begin
    rst = 1'b1; rsta = 1'b0; rstb = 1'b0; regcea = 1'b1; regceb = 1'b1;
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0; addra = '0; addrb = '0; dia = '0; dib = '0;
    idle();
    idle();
    rst = 1'b0;
    checkOutput("reset_doa",      doa_wf, 32'h000000FF);
    checkOutput("reset_dob",      dob_wf, 32'hA5A5A5A5);
    checkOutput("reset_coll",     {31'd0, coll_wf}, 32'd0);
    checkOutput("reset_aerr",     {31'd0, aerr_wf}, 32'd0);
    checkOutput("reset_doa_reg",  doa_pr, 32'h000000FF);
    checkOutput("reset_dob_reg",  dob_pr, 32'hA5A5A5A5);
    checkOutput("reset_flags_rf", {30'd0, coll_rf, aerr_rf}, 32'd0);
    checkOutput("reset_flags_pr", {30'd0, coll_pr, aerr_pr}, 32'd0);

    $display("[TB] write-first readback");
    applyStimulus(1'b1, 4'hF, 9'd5, 32'hDEADBEEF, 1'b0, 4'h0, 9'd0, 32'h0);
    checkOutput("wf_doa",        doa_wf, 32'hDEADBEEF);
    checkOutput("rf_doa_init",   doa_rf, 32'h00000000);
    applyStimulus(1'b0, 4'h0, 9'd0, 32'h0, 1'b1, 4'h0, 9'd5, 32'h0);
    checkOutput("b_read_5",      dob_wf, 32'hDEADBEEF);

    $display("[TB] read-first and no-change");
    applyStimulus(1'b1, 4'hF, 9'd3, 32'h11223344, 1'b0, 4'h0, 9'd0, 32'h0);
    applyStimulus(1'b1, 4'hF, 9'd3, 32'hAABBCCDD, 1'b0, 4'h0, 9'd0, 32'h0);
    checkOutput("rf_old_word",   doa_rf, 32'h11223344);
    checkOutput("wf_new_word",   doa_wf, 32'hAABBCCDD);
    applyStimulus(1'b1, 4'h0, 9'd3, 32'h0, 1'b0, 4'h0, 9'd0, 32'h0);
    checkOutput("rf_readback",   doa_rf, 32'hAABBCCDD);
    applyStimulus(1'b0, 4'h0, 9'd0, 32'h0, 1'b1, 4'hF, 9'd3, 32'h55667788);
    checkOutput("nc_hold",       dob_nc, 32'hDEADBEEF);
    checkOutput("wf_b_write",    dob_wf, 32'h55667788);
    applyStimulus(1'b0, 4'h0, 9'd0, 32'h0, 1'b1, 4'h0, 9'd3, 32'h0);
    checkOutput("nc_readback",   dob_nc, 32'h55667788);

    $display("[TB] byte enables and collision");
    applyStimulus(1'b1, 4'b0011, 9'd7, 32'h11111111, 1'b1, 4'b0110, 9'd7, 32'h22222222);
    checkOutput("coll_overlap",  {31'd0, coll_wf}, 32'd1);
    applyStimulus(1'b1, 4'h0, 9'd7, 32'h0, 1'b0, 4'h0, 9'd0, 32'h0);
    checkOutput("merge_7",       doa_wf, 32'h00221111);
    checkOutput("coll_cleared",  {31'd0, coll_wf}, 32'd0);
    applyStimulus(1'b1, 4'b0001, 9'd8, 32'h000000AA, 1'b1, 4'b0010, 9'd8, 32'h0000BB00);
    checkOutput("coll_disjoint", {31'd0, coll_wf}, 32'd0);
    applyStimulus(1'b1, 4'h0, 9'd8, 32'h0, 1'b0, 4'h0, 9'd0, 32'h0);
    checkOutput("merge_8",       doa_wf, 32'h0000BBAA);

    $display("[TB] registered output latency");
    applyStimulus(1'b0, 4'h0, 9'd0, 32'h0, 1'b1, 4'hF, 9'd9, 32'hCAFEF00D);
    applyStimulus(1'b1, 4'h0, 9'd9, 32'h0, 1'b0, 4'h0, 9'd0, 32'h0);
    checkOutput("reg_lat1",      doa_pr, 32'h0000BBAA);
    idle();
    checkOutput("reg_lat2",      doa_pr, 32'hCAFEF00D);
    regcea = 1'b0;
    applyStimulus(1'b1, 4'h0, 9'd5, 32'h0, 1'b0, 4'h0, 9'd0, 32'h0);
    idle();
    checkOutput("reg_hold",      doa_pr, 32'hCAFEF00D);
    regcea = 1'b1;
    idle();
    checkOutput("reg_release",   doa_pr, 32'hDEADBEEF);

    $display("[TB] port and global reset");
    rsta = 1'b1;
    applyStimulus(1'b1, 4'hF, 9'd10, 32'h12345678, 1'b0, 4'h0, 9'd0, 32'h0);
    rsta = 1'b0;
    checkOutput("rsta_srval",    doa_wf, 32'h000000FF);
    applyStimulus(1'b1, 4'h0, 9'd10, 32'h0, 1'b0, 4'h0, 9'd0, 32'h0);
    checkOutput("rsta_write",    doa_wf, 32'h12345678);
    applyStimulus(1'b1, 4'hF, 9'd13, 32'h00000001, 1'b1, 4'hF, 9'd13, 32'h00000002);
    checkOutput("coll_pre_rst",  {31'd0, coll_wf}, 32'd1);
    rst = 1'b1;
    applyStimulus(1'b1, 4'hF, 9'd10, 32'h0BADF00D, 1'b1, 4'hF, 9'd10, 32'h0BADBEEF);
    rst = 1'b0;
    checkOutput("rst_doa",       doa_wf, 32'h000000FF);
    checkOutput("rst_dob",       dob_wf, 32'hA5A5A5A5);
    checkOutput("rst_coll",      {31'd0, coll_wf}, 32'd0);
    checkOutput("rst_aerr",      {31'd0, aerr_wf}, 32'd0);
    applyStimulus(1'b1, 4'h0, 9'd10, 32'h0, 1'b1, 4'h0, 9'd13, 32'h0);
    checkOutput("rst_mem_kept",  doa_wf, 32'h12345678);
    checkOutput("coll_mem_13",   dob_wf, 32'h00000001);

    $display("[TB] out-of-range access");
    applyStimulus(1'b1, 4'hF, 9'd510, 32'h77777777, 1'b0, 4'h0, 9'd0, 32'h0);
    checkOutput("oor_doa",       doa_wf, 32'h00000000);
    checkOutput("oor_aerr",      {31'd0, aerr_wf}, 32'd1);
    applyStimulus(1'b1, 4'hF, 9'd499, 32'h13579BDF, 1'b0, 4'h0, 9'd0, 32'h0);
    checkOutput("last_doa",      doa_wf, 32'h13579BDF);
    checkOutput("last_aerr",     {31'd0, aerr_wf}, 32'd0);
    applyStimulus(1'b1, 4'h0, 9'd499, 32'h0, 1'b1, 4'h0, 9'd500, 32'h0);
    checkOutput("last_readback", doa_wf, 32'h13579BDF);
    checkOutput("oor_b_dob",     dob_wf, 32'h00000000);
    checkOutput("oor_b_aerr",    {31'd0, aerr_wf}, 32'd1);
    idle();
    checkOutput("aerr_cleared",  {31'd0, aerr_wf}, 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_run);
    $finish;
  end

endmodule

// File: doc/ram_tdp_param.md
Name: ram_tdp_param

Overview:
- Parametrised single-clock true-dual-port block RAM. Successor to the fixed 512x8 dual-port RAM cells.
- Adds configurable width and depth, byte-write enables, and a per-port write mode.
- Adds an optional output pipeline register, a programmable output reset value, and collision detection.
- Used wherever the design needs shared buffer storage between two agents in one clock domain.

Parameters:
- DATA_WIDTH, 32: word width in bits. Must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: bits controlled by each write-enable bit.
- DEPTH, 512: number of words. Need not be a power of two.
- ADDR_WIDTH, 9: address width. Must satisfy 2**ADDR_WIDTH >= DEPTH.
- WRITE_MODE_A, 0: port A write mode. 0 = WRITE_FIRST, 1 = READ_FIRST, 2 = NO_CHANGE.
- WRITE_MODE_B, 0: port B write mode, same encoding.
- DO_REG, 0: 1 adds an output pipeline stage on both ports.
- SRVAL_A, 0: value loaded into the port A output registers on reset.
- SRVAL_B, 0: value loaded into the port B output registers on reset.
- INIT_WORD, 0: initial contents of every memory word.

Ports:
- CLK, input, 1: single clock, all logic on rising edge.
- RST, input, 1: synchronous, active-high global reset.
- ENA, input, 1: port A enable.
- WEA, input, DATA_WIDTH/BYTE_WIDTH: port A byte write enables.
- ADDRA, input, ADDR_WIDTH: port A address.
- DIA, input, DATA_WIDTH: port A write data.
- RSTA, input, 1: port A synchronous output reset.
- REGCEA, input, 1: port A pipeline register clock enable. Used only when DO_REG=1.
- DOA, output, DATA_WIDTH: port A read data.
- ENB, WEB, ADDRB, DIB, RSTB, REGCEB, DOB: port B equivalents of the port A signals.
- COLL, output, 1: registered flag; write/write collision in the previous cycle.
- ADDR_ERR, output, 1: registered flag; an enabled access used an address >= DEPTH in the previous cycle.

Behaviour:
- Reset:
  - RST=1 at a clock edge loads SRVAL_A/SRVAL_B into both output latches and both pipeline registers, and clears COLL and ADDR_ERR.
  - Memory contents are not affected by any reset.
  - RST overrides every other input in that cycle; no writes occur.
- Port reset: RSTA=1 with ENA=1 loads SRVAL_A into the A output latch. A write requested in the same cycle still occurs. Port B behaves the same with RSTB/ENB/SRVAL_B.
- Read latency: 1 cycle when DO_REG=0; 2 cycles when DO_REG=1.
  - With DO_REG=1, the pipeline register loads only when REGCEx=1, or when RSTx=1 (loads SRVALx).
- Disabled port: ENx=0 means no read, no write, and the output latch holds its value.
- Write: each byte lane i of mem[ADDRx] is updated when WEx[i]=1. Output latch on a write cycle by mode:
  - WRITE_FIRST: the new word (merged bytes).
  - READ_FIRST: the old word.
  - NO_CHANGE: latch holds.
- Read with WEx all zero: the latch takes mem[ADDRx].
- Cross-port, same address, same cycle:
  - One port reads, the other writes: the reading port returns the old word.
  - Both ports write: for each byte enabled on both ports, port A's data wins; bytes enabled on only one port take that port's data.
  - COLL goes to 1 in the next cycle when at least one byte overlaps; otherwise COLL is 0.
- Out-of-range address (ADDRx >= DEPTH, ENx=1):
  - Write is dropped and the read latch loads 0.
  - ADDR_ERR goes to 1 in the next cycle.
- Initial contents: every word equals INIT_WORD at time zero.

Decomposition:
- Shared package ram_pkg holds:
  - WM_WRITE_FIRST = 0, WM_READ_FIRST = 1, WM_NO_CHANGE = 2.
  - Function clog2.
  - Function nbytes(DATA_WIDTH, BYTE_WIDTH).
- Sub-module ram_tdp_port_out, instantiated once per port, contains:
  - the output latch, with write-mode select and RSTx/SRVAL handling;
  - the optional DO_REG pipeline stage.
- The top level holds the memory array, byte merge, collision logic and address checks.

Test Plan:
1. Write-first readback: DATA_WIDTH=32, WRITE_MODE_A=0. Write A addr 5 = 0xDEADBEEF with WEA=4'hF → DOA=0xDEADBEEF on the next cycle. Then read B addr 5 → DOB=0xDEADBEEF one cycle later.
2. Read-first and no-change: mem[3]=0x11223344.
   - READ_FIRST: write 0xAABBCCDD to addr 3 → DOA=0x11223344. A following read returns 0xAABBCCDD.
   - NO_CHANGE: DOA keeps its prior value during the write.
3. Byte enables plus collision: mem[7]=0x00000000.
   - Same cycle: A writes 0x11111111 with WEA=4'b0011; B writes 0x22222222 with WEB=4'b0110.
   - Result: mem[7]=0x00221111 and COLL=1 on the next cycle.
   - Non-overlapping byte enables at the same address → COLL=0.
4. DO_REG=1 latency: read addr 9 holding 0xCAFEF00D with REGCEA=1 → DOA=0xCAFEF00D two cycles later. With REGCEA=0, DOA holds its previous value.
5. Resets: SRVAL_A=0x000000FF.
   - Assert RSTA with ENA=1 and WEA=4'hF → DOA=0x000000FF and the write still lands.
   - Assert RST mid-burst → DOA=0xFF, DOB=SRVAL_B, COLL=0, ADDR_ERR=0, memory preserved.
6. Out-of-range access: DEPTH=500. Write addr 510 → no memory change, DOA=0, ADDR_ERR=1 on the next cycle. Addr 499 works normally.
